// File: rtl/regbank_sb_if.sv
// Handshake and data bundle for regbank_sb.
// The issue/writeback side drives it through master; the bank uses slave.
interface regbank_sb_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5
);
    localparam int DEPTH = 2 ** AWIDTH;

    logic              we0;
    logic [AWIDTH-1:0] wa0;
    logic [DWIDTH-1:0] wd0;
    logic              we1;
    logic [AWIDTH-1:0] wa1;
    logic [DWIDTH-1:0] wd1;
    logic              rsv_en;
    logic [AWIDTH-1:0] rsv_addr;
    logic              rd_en;
    logic [AWIDTH-1:0] sr1;
    logic [AWIDTH-1:0] sr2;
    logic              rd_ready;
    logic              rd_valid;
    logic [DWIDTH-1:0] rddata1;
    logic [DWIDTH-1:0] rddata2;
    logic [DEPTH-1:0]  busy;

    modport master (
        output we0, wa0, wd0, we1, wa1, wd1,
        output rsv_en, rsv_addr, rd_en, sr1, sr2,
        input  rd_ready, rd_valid, rddata1, rddata2, busy
    );

    modport slave (
        input  we0, wa0, wd0, we1, wa1, wd1,
        input  rsv_en, rsv_addr, rd_en, sr1, sr2,
        output rd_ready, rd_valid, rddata1, rddata2, busy
    );
endinterface

// File: rtl/regbank_sb.sv
// Two-write/two-read register bank with registered reads,
// same-cycle write bypass and a pending-write scoreboard.
module regbank_sb #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 5,
    parameter int ZERO_REG = 1
) (
    input logic         clk,
    input logic         rst,
    regbank_sb_if.slave bus
);
    localparam int DEPTH = 2 ** AWIDTH;

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic              r_valid;
    logic [DWIDTH-1:0] r_rd1;
    logic [DWIDTH-1:0] r_rd2;

    logic              w_we0;
    logic              w_we1;
    logic              w_rsv;
    logic [AWIDTH-1:0] w_src [2];
    logic [DWIDTH-1:0] w_eff [2];
    logic [1:0]        w_hit0;
    logic [1:0]        w_hit1;
    logic [1:0]        w_stall;
    logic              w_ready;
    logic              w_accept;
    logic [DEPTH-1:0]  w_busy_nxt;

    // Register 0 is hardwired when ZERO_REG is set, so drop its writes.
    assign w_we0 = bus.we0 && !(ZERO_REG != 0 && bus.wa0 == '0);
    assign w_we1 = bus.we1 && !(ZERO_REG != 0 && bus.wa1 == '0);
    assign w_rsv = bus.rsv_en
                && !(ZERO_REG != 0 && bus.rsv_addr == '0);

    assign w_src[0] = bus.sr1;
    assign w_src[1] = bus.sr2;

    // Effective source value with port 1 over port 0 bypass, and stall.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w_hit0[s] = w_we0 && (bus.wa0 == w_src[s]);
            w_hit1[s] = w_we1 && (bus.wa1 == w_src[s]);
            w_eff[s]  = r_mem[w_src[s]];
            if (w_hit0[s]) w_eff[s] = bus.wd0;
            if (w_hit1[s]) w_eff[s] = bus.wd1;
            if (ZERO_REG != 0 && w_src[s] == '0) w_eff[s] = '0;
            w_stall[s] = r_busy[w_src[s]] && !w_hit0[s] && !w_hit1[s];
        end
    end

    assign w_ready  = ~|w_stall;
    assign w_accept = bus.rd_en && w_ready;

    // Writeback clears pending, then a reserve on the same address wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_we0) w_busy_nxt[bus.wa0] = 1'b0;
        if (w_we1) w_busy_nxt[bus.wa1] = 1'b0;
        if (w_rsv) w_busy_nxt[bus.rsv_addr] = 1'b1;
    end

    // Array update; port 1 is applied last so it wins on a collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_we0) r_mem[bus.wa0] <= bus.wd0;
            if (w_we1) r_mem[bus.wa1] <= bus.wd1;
        end
    end

    // Scoreboard of registers with a write still outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_busy <= '0;
        else      r_busy <= w_busy_nxt;
    end

    // Registered read port; data holds when no read is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_rd1   <= '0;
            r_rd2   <= '0;
        end else begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_rd1 <= w_eff[0];
                r_rd2 <= w_eff[1];
            end
        end
    end

    assign bus.rd_ready = w_ready;
    assign bus.rd_valid = r_valid;
    assign bus.rddata1  = r_rd1;
    assign bus.rddata2  = r_rd2;
    assign bus.busy     = r_busy;
endmodule

// File: tb/tb_regbank_sb.sv
// Directed bench for regbank_sb with a behavioural reference model
// checked every cycle plus literal expectations on key results.
module tb_regbank_sb;
    logic clk;
    logic rst;

    regbank_sb_if #(.DWIDTH(32), .AWIDTH(5)) bus ();

    regbank_sb #(.DWIDTH(32), .AWIDTH(5), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    bit [31:0] m_mem [32];
    bit [31:0] m_busy;
    bit        m_valid;
    bit [31:0] m_rd1;
    bit [31:0] m_rd2;

    function automatic bit wr_hit(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        return (bus.we0 && bus.wa0 == a) || (bus.we1 && bus.wa1 == a);
    endfunction

    function automatic bit [31:0] eff(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (bus.we1 && bus.wa1 == a) return bus.wd1;
        if (bus.we0 && bus.wa0 == a) return bus.wd0;
        return m_mem[a];
    endfunction

    function automatic bit exp_ready();
        bit s1;
        bit s2;
        s1 = m_busy[bus.sr1] && !wr_hit(bus.sr1);
        s2 = m_busy[bus.sr2] && !wr_hit(bus.sr2);
        return !(s1 || s2);
    endfunction

    function automatic bit [31:0] next_busy();
        bit [31:0] b;
        b = m_busy;
        if (bus.we0) b[bus.wa0] = 1'b0;
        if (bus.we1) b[bus.wa1] = 1'b0;
        if (bus.rsv_en) b[bus.rsv_addr] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    // Reference model state, advanced on the same edges as the bank.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_mem[i] <= '0;
            m_busy  <= '0;
            m_valid <= 1'b0;
            m_rd1   <= '0;
            m_rd2   <= '0;
        end else begin
            if (bus.rd_en && exp_ready()) begin
                m_valid <= 1'b1;
                m_rd1   <= eff(bus.sr1);
                m_rd2   <= eff(bus.sr2);
            end else begin
                m_valid <= 1'b0;
            end
            m_busy <= next_busy();
            if (bus.we0 && bus.wa0 != 5'd0) m_mem[bus.wa0] <= bus.wd0;
            if (bus.we1 && bus.wa1 != 5'd0) m_mem[bus.wa1] <= bus.wd1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Per-cycle compare, mid-way between the falling and rising edge.
    always begin
        @(negedge clk);
        #3;
        chk("busy", bus.busy, m_busy);
        chk("rd_ready", {31'd0, bus.rd_ready}, {31'd0, exp_ready()});
        chk("rd_valid", {31'd0, bus.rd_valid}, {31'd0, m_valid});
        chk("rddata1", bus.rddata1, m_rd1);
        chk("rddata2", bus.rddata2, m_rd2);
    end

    task automatic idle();
        bus.we0 = 0; bus.wa0 = '0; bus.wd0 = '0;
        bus.we1 = 0; bus.wa1 = '0; bus.wd1 = '0;
        bus.rsv_en = 0; bus.rsv_addr = '0;
        bus.rd_en = 0; bus.sr1 = '0; bus.sr2 = '0;
    endtask

    task automatic cyc();
        @(negedge clk);
        idle();
    endtask

    task automatic rd(input logic [4:0] a, input logic [4:0] b);
        bus.rd_en = 1; bus.sr1 = a; bus.sr2 = b;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        @(negedge clk);
        #1;
        chk("reset busy", bus.busy, 32'd0);
        chk("reset valid", {31'd0, bus.rd_valid}, 32'd0);
        chk("reset rddata1", bus.rddata1, 32'd0);
        #1 rst = 1'b1;

        // Fill reg k with 10*k through port 0.
        for (int k = 0; k < 32; k++) begin
            cyc();
            bus.we0 = 1; bus.wa0 = 5'(k); bus.wd0 = 32'(10 * k);
        end

        // Back-to-back pair reads; each result one edge after rd_en.
        for (int k = 0; k < 31; k++) begin
            cyc();
            rd(5'(k), 5'(k + 1));
            if (k > 0) begin
                #3;
                chk("pair valid", {31'd0, bus.rd_valid}, 32'd1);
                chk("pair rd1", bus.rddata1,
                    (k == 1) ? 32'd0 : 32'(10 * (k - 1)));
                chk("pair rd2", bus.rddata2, 32'(10 * k));
            end
        end
        cyc();
        #3;
        chk("pair last rd1", bus.rddata1, 32'd300);
        chk("pair last rd2", bus.rddata2, 32'd310);
        cyc();
        #3;
        chk("valid drops", {31'd0, bus.rd_valid}, 32'd0);

        // Dual write collision and same-cycle bypass.
        cyc();
        bus.we0 = 1; bus.wa0 = 5'd7; bus.wd0 = 32'h11;
        bus.we1 = 1; bus.wa1 = 5'd7; bus.wd1 = 32'h22;
        cyc();
        rd(5'd7, 5'd7);
        cyc();
        bus.we0 = 1; bus.wa0 = 5'd3; bus.wd0 = 32'h55;
        rd(5'd3, 5'd7);
        #3;
        chk("collision p1 wins", bus.rddata1, 32'h22);
        cyc();
        #3;
        chk("bypass rd1", bus.rddata1, 32'h55);
        chk("bypass rd2", bus.rddata2, 32'h22);

        // Reserve 5, stall, then release in the writeback cycle.
        cyc();
        bus.rsv_en = 1; bus.rsv_addr = 5'd5;
        cyc();
        rd(5'd5, 5'd1);
        #3;
        chk("rsv5 busy", {31'd0, bus.busy[5]}, 32'd1);
        chk("rsv5 stall", {31'd0, bus.rd_ready}, 32'd0);
        cyc();
        rd(5'd5, 5'd1);
        #3;
        chk("rsv5 no valid", {31'd0, bus.rd_valid}, 32'd0);
        cyc();
        rd(5'd5, 5'd1);
        bus.we1 = 1; bus.wa1 = 5'd5; bus.wd1 = 32'h99;
        #3;
        chk("wb ready", {31'd0, bus.rd_ready}, 32'd1);
        cyc();
        #3;
        chk("wb valid", {31'd0, bus.rd_valid}, 32'd1);
        chk("wb data", bus.rddata1, 32'h99);
        chk("wb busy clr", {31'd0, bus.busy[5]}, 32'd0);

        // Reserve and write 9 together: reserve wins.
        cyc();
        bus.rsv_en = 1; bus.rsv_addr = 5'd9;
        bus.we0 = 1; bus.wa0 = 5'd9; bus.wd0 = 32'hAB;
        cyc();
        rd(5'd9, 5'd9);
        #3;
        chk("rsv9 busy", {31'd0, bus.busy[9]}, 32'd1);
        chk("rsv9 stall", {31'd0, bus.rd_ready}, 32'd0);
        cyc();
        rd(5'd9, 5'd2);
        bus.we0 = 1; bus.wa0 = 5'd9; bus.wd0 = 32'hCD;
        cyc();
        #3;
        chk("rsv9 release", bus.rddata1, 32'hCD);

        // Register 0 ignores reserve and write.
        cyc();
        bus.rsv_en = 1; bus.rsv_addr = 5'd0;
        bus.we0 = 1; bus.wa0 = 5'd0; bus.wd0 = 32'hFFFF_FFFF;
        cyc();
        rd(5'd0, 5'd0);
        #3;
        chk("r0 busy", {31'd0, bus.busy[0]}, 32'd0);
        chk("r0 ready", {31'd0, bus.rd_ready}, 32'd1);
        cyc();
        #3;
        chk("r0 data", bus.rddata1, 32'd0);

        // Asynchronous reset in the middle of a read.
        cyc();
        bus.rsv_en = 1; bus.rsv_addr = 5'd12;
        cyc();
        rd(5'd1, 5'd2);
        cyc();
        #1;
        chk("pre-rst valid", {31'd0, bus.rd_valid}, 32'd1);
        chk("pre-rst rd1", bus.rddata1, 32'd10);
        #1 rst = 1'b0;
        #1;
        chk("rst valid", {31'd0, bus.rd_valid}, 32'd0);
        chk("rst busy", bus.busy, 32'd0);
        chk("rst rd1", bus.rddata1, 32'd0);
        chk("rst rd2", bus.rddata2, 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        cyc();
        rd(5'd1, 5'd7);
        cyc();
        rd(5'd2, 5'd9);
        #3;
        chk("post-rst r1", bus.rddata1, 32'd0);
        chk("post-rst r7", bus.rddata2, 32'd0);
        chk("post-rst valid", {31'd0, bus.rd_valid}, 32'd1);
        cyc();
        #3;
        chk("post-rst r2", bus.rddata1, 32'd0);
        chk("post-rst r9", bus.rddata2, 32'd0);
        cyc();
        #4;

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end
endmodule
